// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI master bridge.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic SPI_WRITE = 1'b1;
  localparam logic SPI_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: alternating rise/fall tick pulses every CLK_DIV cycles while enabled.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic          phase_r;
  logic          tick_s;

  assign tick_s    = en && (cnt_r == CW'(CLK_DIV - 1));
  assign rise_tick = tick_s && !phase_r;
  assign fall_tick = tick_s && phase_r;

  // Half-period counter and phase; both restart whenever the frame is not running
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_r   <= CW'(0);
      phase_r <= 1'b0;
    end else if (!en) begin
      cnt_r   <= CW'(0);
      phase_r <= 1'b0;
    end else if (tick_s) begin
      cnt_r   <= CW'(0);
      phase_r <= !phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_bridge.sv
// Register-access SPI master (mode 0): one command in, one serial frame out, one response back.
module spi_master_bridge
  import spi_bridge_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CSN_GAP = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_clk,
  output logic              spi_csn,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int BW      = $clog2(FRAME_W + 1);
  localparam int GW      = $clog2(CSN_GAP + 1) + 1;

  state_t              state_r, state_nx_s;
  logic                cmd_ready_r, rsp_valid_r, spi_clk_r, spi_csn_r, spi_mosi_r, sample_r;
  logic [DATA_W-1:0]   rsp_rdata_r, rx_r;
  logic [FRAME_W-1:0]  tx_r;
  logic [BW-1:0]       bit_cnt_r;
  logic [GW-1:0]       gap_cnt_r;
  logic                rise_s, fall_s, accept_s, frame_done_s, gap_done_s;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .res       (res),
    .en        (state_r == SHIFT),
    .rise_tick (rise_s),
    .fall_tick (fall_s)
  );

  assign accept_s     = (state_r == IDLE) && cmd_valid && cmd_ready_r;
  // The tick after the last falling edge closes the trailing low phase.
  assign frame_done_s = rise_s && (bit_cnt_r == BW'(FRAME_W));
  assign gap_done_s   = (gap_cnt_r >= GW'(CSN_GAP));

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (accept_s)     state_nx_s = SHIFT; else state_nx_s = IDLE;
      SHIFT:   if (frame_done_s) state_nx_s = RESP;  else state_nx_s = SHIFT;
      RESP:    if (rsp_ready)    state_nx_s = GAP;   else state_nx_s = RESP;
      GAP:     if (gap_done_s)   state_nx_s = IDLE;  else state_nx_s = GAP;
      default:                   state_nx_s = IDLE;
    endcase
  end

  // FSM, shift registers, gap counter and all registered outputs
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= DATA_W'(0);
      spi_clk_r   <= 1'b0;
      spi_csn_r   <= 1'b1;
      spi_mosi_r  <= 1'b0;
      sample_r    <= 1'b0;
      tx_r        <= FRAME_W'(0);
      rx_r        <= DATA_W'(0);
      bit_cnt_r   <= BW'(0);
      gap_cnt_r   <= GW'(0);
    end else begin
      state_r     <= state_nx_s;
      cmd_ready_r <= (state_nx_s == IDLE);
      sample_r    <= rise_s && !frame_done_s;
      if (accept_s) begin
        tx_r       <= {cmd_write, cmd_addr, (cmd_write == SPI_WRITE) ? cmd_wdata : DATA_W'(0)};
        spi_mosi_r <= cmd_write;
        spi_csn_r  <= 1'b0;
        bit_cnt_r  <= BW'(0);
      end else if (state_r == SHIFT) begin
        if (frame_done_s) begin
          spi_csn_r   <= 1'b1;
          spi_mosi_r  <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= rx_r;
          gap_cnt_r   <= GW'(1);
        end else if (rise_s) begin
          spi_clk_r <= 1'b1;
        end else if (fall_s) begin
          spi_clk_r  <= 1'b0;
          spi_mosi_r <= tx_r[FRAME_W-2];
          tx_r       <= {tx_r[FRAME_W-2:0], 1'b0};
          bit_cnt_r  <= bit_cnt_r + BW'(1);
        end
      end else begin
        if (rsp_valid_r && rsp_ready) rsp_valid_r <= 1'b0;
        // Saturating count of cycles since spi_csn rose; RESP time counts toward the gap.
        if (gap_cnt_r < GW'(CSN_GAP)) gap_cnt_r <= gap_cnt_r + GW'(1);
      end
      if (sample_r) rx_r <= {rx_r[DATA_W-2:0], spi_miso};
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign spi_clk   = spi_clk_r;
  assign spi_csn   = spi_csn_r;
  assign spi_mosi  = spi_mosi_r;

endmodule

// File: doc/spi_master_bridge.md
# spi_master_bridge

Clocked SPI master that turns register-access commands into serial frames on the chip's `spi_clk`/`spi_csn`/`spi_mosi`/`spi_miso` slave port and returns captured read data. It sits directly upstream of the chip top-level SPI slave. It serves as the synthesizable stimulus engine of the simulation harness and of the FPGA test harness, replacing hand-written bit-banging tasks. Commands and responses use valid/ready handshakes.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per SPI clock half-period; must be ≥1.
- `CSN_GAP`, 4: minimum `clk` cycles `spi_csn` stays high between frames; must be ≥1.
- `ADDR_W`, 7: register address width.
- `DATA_W`, 8: register data width. Frame width is `FRAME_W = 1+ADDR_W+DATA_W`, which is 16 with the defaults.

Ports:
- `clk`  in  1  system clock; the only clock.
- `res`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  bridge accepts a command this cycle.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  register address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  DATA_W  data bits sampled from `spi_miso`.
- `spi_clk`  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_csn`  out  1  chip select, active-low.
- `spi_mosi`  out  1  serial data to the slave, MSB first.
- `spi_miso`  in  1  serial data from the slave.

## Operation
- Frame layout on `spi_mosi`, MSB first: `{cmd_write, cmd_addr, cmd_wdata}`. A read sends `cmd_wdata` as zeros.
- FSM states and transitions:
  - IDLE → SHIFT when `cmd_valid & cmd_ready`. The frame is latched into the TX shift register.
  - SHIFT: clocks out FRAME_W bits. After the last falling edge plus one low phase, it goes to RESP.
  - RESP: `spi_csn` is high and `rsp_valid`=1. On `rsp_ready` it goes to GAP.
  - GAP: counts CSN_GAP cycles from the `spi_csn` rising edge, then goes to IDLE. If RESP already lasted ≥CSN_GAP cycles, GAP takes a single cycle.
- `cmd_ready` = (state == IDLE). There is no command queueing.
- `spi_mosi` changes only while `spi_clk` is low.
- `spi_miso` is sampled in the `clk` cycle in which `spi_clk` rises, and shifted into the RX register.
- `rsp_rdata` holds the last DATA_W sampled bits. These are the data-phase bits for both reads and writes.
- `rsp_rdata` is stable while `rsp_valid` is high.
- Reset values: `cmd_ready`=0 while `res` is asserted and 1 in the first cycle after release. `rsp_valid`=0, `rsp_rdata`=0, `spi_clk`=0, `spi_csn`=1, `spi_mosi`=0.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). Any in-flight command and response are discarded. No partial response is issued.
- `spi_miso` is used only at the sample points. X on `spi_miso` outside those points has no effect.

## Timing
- Let A be the acceptance cycle. At A+1, `spi_csn` falls and `spi_mosi` = bit FRAME_W-1.
- Rising edge k (k = 0..FRAME_W-1) occurs at A+1+CLK_DIV·(2k+1).
- The falling edge after rising edge k occurs CLK_DIV cycles later, and `spi_mosi` advances to the next bit in the same cycle.
- `spi_csn` is low for exactly CLK_DIV·(2·FRAME_W+1) cycles. With the defaults this is 132; with CLK_DIV=2 it is 66.
- `rsp_valid` rises in the same cycle `spi_csn` rises.
- If `rsp_ready` is continuously high and the next command is waiting, the next `spi_csn` fall is exactly CSN_GAP+1 cycles after the previous rise.
- `spi_clk` is low whenever `spi_csn` is high. There are no glitches; all SPI outputs are registered.

## Structure
- Package `spi_bridge_pkg` contains:
  - the state enum (IDLE, SHIFT, RESP, GAP);
  - the `FRAME_W` localparam function;
  - constants `SPI_WRITE`=1 and `SPI_READ`=0.
- Sub-module `spi_tick_gen`: a CLK_DIV half-period counter, enabled in SHIFT, that outputs `rise_tick`/`fall_tick` pulses. The top level holds the FSM, the shift registers and the gap counter.

## Test plan
- Write, CLK_DIV=2, addr 0x05, wdata 0xA5:
  - MOSI sampled on rising edges = 0x85A5.
  - `spi_csn` low for 66 cycles.
  - `rsp_valid` pulses once with `rsp_ready`=1.
- Read, addr 0x12, slave model drives 0x3C in the data phase:
  - MOSI = 0x1200.
  - `rsp_rdata` = 0x3C.
- Back-to-back: two commands presented with `cmd_valid` held, `rsp_ready`=1, CSN_GAP=4:
  - second `spi_csn` fall exactly 5 cycles after the first rise;
  - `cmd_ready` low throughout the first frame.
- Response backpressure: `rsp_ready`=0 for 20 cycles:
  - `rsp_valid` and `rsp_rdata` are held;
  - `cmd_ready` stays 0;
  - no new frame starts until 1 cycle after the handshake.
- Reset at rising edge 7 of a frame:
  - `spi_csn`=1 and `spi_clk`=0 immediately;
  - no `rsp_valid`;
  - the next command after release produces a clean full frame.
- CLK_DIV=1 corner: write addr 0x7F, wdata 0xFF:
  - `spi_clk` toggles every cycle;
  - MOSI = 0xFFFF;
  - `spi_csn` low for 33 cycles.
